keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad (Pmod KYPD on a Pmod header) and delivers debounced key codes through a valid/ready handshake. It is the input-side counterpart of the multiplexed 7-segment driver: it strobes columns instead of anodes and reads rows instead of driving cathodes. In the calculator top level it sits between the Pmod pins and the operand/opcode loading logic, replacing the slide switches as the data source.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_scanner_if.sv | 24 ++
 rtl/row_synchronizer.sv | 24 ++
 rtl/keypad_scanner.sv | 208 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, key-code table and press-FSM state type for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;

  // Indexed by row*4 + col; entry 0 is row 0 / col 0.
  localparam logic [15:0][3:0] KEY_TABLE = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  typedef enum logic [1:0] {
    StReleased,
    StDebPress,
    StPressed,
    StDebRelease
  } press_state_e;

  function automatic logic [3:0] key_code_of(logic [3:0] idx);
    return KEY_TABLE[idx];
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key stream from the scanner to its consumer: code/valid/ready handshake plus status flags.
interface keypad_scanner_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;
  logic       overrun;

  modport master (
    output key_code,
    output key_valid,
    output key_held,
    output overrun,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_held,
    input  overrun,
    output key_ready
  );
endinterface

// File: rtl/row_synchronizer.sv
// Two-flop synchronizer for the asynchronous, active-low keypad row lines; resets to idle (1111).
module row_synchronizer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] row_n_i,
  output logic [3:0] row_n_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= row_n_i;
      sync_q <= meta_q;
    end
  end

  assign row_n_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobing, per-scan debounce FSM and a one-entry key buffer.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100_000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_DELAY   = 125,
  parameter int unsigned REPEAT_PERIOD  = 25
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [3:0]        col_n,
  input  logic [3:0]        row_n,
  keypad_scanner_if.master  key_if
);

  localparam int unsigned      DivW     = $clog2(SCAN_DIV);
  localparam logic [DivW-1:0]  DivLast  = DivW'(SCAN_DIV - 1);
  localparam logic [15:0]      DebScans = 16'(DEBOUNCE_SCANS);

  logic [3:0]      row_sync;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      col_q, col_d;
  logic [15:0]     snap_q, snap_d;
  press_state_e    state_q, state_d;
  logic [15:0]     cnt_q, cnt_d, cnt_inc;
  logic [3:0]      key_q, key_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;
  logic            overrun_q, overrun_d;

  logic            sample, scan_end;
  logic            cand_valid, same_key, emit, xfer;
  logic [3:0]      cand_idx, bit_idx;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] RepDelay  = 16'(REPEAT_DELAY);
  localparam logic [15:0] RepPeriod = 16'(REPEAT_PERIOD);
  logic [15:0] rep_cnt_q, rep_cnt_d, rep_inc;
  logic        rep_again_q, rep_again_d;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  row_synchronizer u_row_sync (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .row_n_i (row_n),
    .row_n_o (row_sync)
  );

  // Column dwell counter and snapshot capture; evaluation shares the last sample cycle.
  always_comb begin
    sample   = (div_q == DivLast);
    scan_end = sample && (col_q == 2'd3);
    div_d    = sample ? '0 : div_q + 1'b1;
    col_d    = sample ? col_q + 2'd1 : col_q;
    snap_d   = snap_q;
    bit_idx  = '0;
    if (sample) begin
      for (int r = 0; r < ROWS; r++) begin
        bit_idx         = {2'(r), col_q};
        snap_d[bit_idx] = ~row_sync[2'(r)];
      end
    end
    cand_valid = ($countones(snap_d) == 1);
    cand_idx   = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_d[4'(i)]) cand_idx = 4'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    emit     = 1'b0;
    same_key = cand_valid && (cand_idx == key_q);
    cnt_inc  = cnt_q + 16'd1;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_again_d = rep_again_q;
    rep_inc     = rep_cnt_q + 16'd1;
`endif
    if (scan_end) begin
      unique case (state_q)
        StReleased: begin
          if (cand_valid) begin
            key_d = cand_idx;
            cnt_d = 16'd1;
            if (DebScans <= 16'd1) begin
              state_d = StPressed;
              emit    = 1'b1;
            end else begin
              state_d = StDebPress;
            end
          end
        end
        StDebPress: begin
          if (same_key) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DebScans) begin
              state_d = StPressed;
              emit    = 1'b1;
            end
          end else begin
            state_d = StReleased;
          end
        end
        StPressed: begin
          if (same_key) begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_inc >= (rep_again_q ? RepPeriod : RepDelay)) begin
              emit        = 1'b1;
              rep_cnt_d   = '0;
              rep_again_d = 1'b1;
            end else begin
              rep_cnt_d = rep_inc;
            end
`endif
          end else begin
            cnt_d   = 16'd1;
            state_d = (DebScans <= 16'd1) ? StReleased : StDebRelease;
          end
        end
        StDebRelease: begin
          if (same_key) begin
            state_d = StPressed;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DebScans) state_d = StReleased;
          end
        end
        default: state_d = StReleased;
      endcase
`ifdef KEYPAD_REPEAT_EN
      // Any scan that is not a continued hold restarts the repeat schedule.
      if (!(state_q == StPressed && state_d == StPressed)) begin
        rep_cnt_d   = '0;
        rep_again_d = 1'b0;
      end
`endif
    end
  end

  // One-entry buffer: a new key may replace the old one only in a transfer cycle.
  always_comb begin
    xfer      = valid_q && key_if.key_ready;
    code_d    = code_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (emit) begin
      if (!valid_q || xfer) begin
        code_d  = key_code_of(key_d);
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    held_d = (state_d == StPressed) || (state_d == StDebRelease);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q       <= '0;
      col_q       <= '0;
      snap_q      <= '0;
      state_q     <= StReleased;
      cnt_q       <= '0;
      key_q       <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      held_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_again_q <= 1'b0;
`endif
    end else begin
      div_q       <= div_d;
      col_q       <= col_d;
      snap_q      <= snap_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      held_q      <= held_d;
      overrun_q   <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_again_q <= rep_again_d;
`endif
    end
  end

  assign col_n            = ~(4'b0001 << col_q);
  assign key_if.key_code  = code_q;
  assign key_if.key_valid = valid_q;
  assign key_if.key_held  = held_q;
  assign key_if.overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad model, per-scan press/release reference and
// per-cycle buffer model, with directed scenarios followed by random key patterns.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV   = 4;
  localparam int unsigned DEB        = 2;
  localparam int unsigned REP_DELAY  = 3;
  localparam int unsigned REP_PERIOD = 2;
  localparam int unsigned SCAN_LEN   = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] pressed = '0;

  keypad_scanner_if key_if ();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB),
    .REPEAT_DELAY   (REP_DELAY),
    .REPEAT_PERIOD  (REP_PERIOD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .col_n   (col_n),
    .row_n   (row_n),
    .key_if  (key_if)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column; rows idle high.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
    end
  end

  int unsigned key_tbl [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

  int n_checks = 0;
  int n_errors = 0;
  int k = 0;
  int obs_valid = 0;
  int obs_over = 0;

  // Reference state.
  bit m_valid, m_held, m_overrun;
  int m_code, run, run_key, held_key, rel, rep;
  bit rep_again;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_held = 0; m_overrun = 0; m_code = 0;
    run = 0; run_key = 0; held_key = 0; rel = 0; rep = 0; rep_again = 0;
  endtask

  function automatic int cand_of(logic [15:0] p);
    if ($countones(p) != 1) return -1;
    for (int i = 0; i < 16; i++) if (p[i]) return i;
    return -1;
  endfunction

  // One full-scan observation: decide press/release/repeat events.
  task automatic model_scan(input int cand, output bit emit, output int code);
    emit = 0;
    code = 0;
    if (!m_held) begin
      if (cand >= 0 && run > 0 && cand == run_key) run++;
      else if (cand >= 0 && run == 0) begin
        run = 1;
        run_key = cand;
      end else run = 0;
      if (run >= int'(DEB)) begin
        m_held = 1; held_key = run_key; run = 0; rel = 0; rep = 0; rep_again = 0;
        emit = 1; code = int'(key_tbl[held_key]);
      end
    end else if (cand == held_key) begin
      if (rel > 0) begin
        rel = 0; rep = 0; rep_again = 0;
      end else begin
`ifdef KEYPAD_REPEAT_EN
        rep++;
        if (rep >= int'(rep_again ? REP_PERIOD : REP_DELAY)) begin
          rep = 0; rep_again = 1; emit = 1; code = int'(key_tbl[held_key]);
        end
`endif
      end
    end else begin
      rel++;
      if (rel >= int'(DEB)) begin
        m_held = 0; run = 0;
      end
    end
  endtask

  // Called at a falling edge: check outputs, drive key_ready, advance the model one cycle.
  task automatic tick(input bit ready);
    int phase;
    bit emit, xfer;
    int code;
    logic [3:0] exp_col;
    phase = k % int'(SCAN_LEN);
    exp_col = ~(4'b0001 << (phase / int'(SCAN_DIV)));
    check_eq("col_n", col_n, exp_col);
    check_eq("key_valid", key_if.key_valid, m_valid);
    check_eq("key_code", key_if.key_code, m_code);
    check_eq("key_held", key_if.key_held, m_held);
    check_eq("overrun", key_if.overrun, m_overrun);
    if (key_if.key_valid) obs_valid++;
    if (key_if.overrun) obs_over++;
    key_if.key_ready = ready;
    emit = 0;
    code = 0;
    if (phase == int'(SCAN_LEN) - 1) model_scan(cand_of(pressed), emit, code);
    xfer = m_valid && ready;
    m_overrun = 0;
    if (emit) begin
      if (!m_valid || xfer) begin
        m_code = code;
        m_valid = 1;
      end else m_overrun = 1;
    end else if (xfer) m_valid = 0;
    k++;
    @(negedge clk);
  endtask

  // mode: 0 ready low, 1 ready high, 2 ready random per cycle.
  task automatic run_scan(input logic [15:0] p, input int mode);
    pressed = p;
    for (int c = 0; c < int'(SCAN_LEN); c++) begin
      tick(mode == 2 ? ($urandom_range(0, 3) != 0) : (mode == 1));
    end
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst col_n", col_n, 4'b1110);
    check_eq("rst key_valid", key_if.key_valid, 0);
    check_eq("rst key_held", key_if.key_held, 0);
    check_eq("rst overrun", key_if.overrun, 0);
    check_eq("rst key_code", key_if.key_code, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    k = 0;
  endtask

  logic [15:0] rp, prev;

  initial begin
    key_if.key_ready = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle scanning.
    obs_valid = 0;
    for (int s = 0; s < 10; s++) run_scan('0, 1);
    check_eq("idle valid cycles", obs_valid, 0);

    // Single key '6' held 4 scans then released.
    obs_valid = 0;
    for (int s = 0; s < 4; s++) run_scan(16'(1 << 6), 1);
    for (int s = 0; s < 3; s++) run_scan('0, 1);
    check_eq("key6 valid cycles", obs_valid, 1);

    // Bouncing 'A' never survives debounce.
    obs_valid = 0;
    for (int s = 0; s < 8; s++) run_scan((s % 2 == 0) ? 16'(1 << 3) : 16'h0, 1);
    check_eq("bounce valid cycles", obs_valid, 0);

    // Two keys at once are rejected.
    obs_valid = 0;
    for (int s = 0; s < 6; s++) run_scan(16'((1 << 0) | (1 << 9)), 1);
    check_eq("ghost valid cycles", obs_valid, 0);

    // Buffer full: '5' pending, 'A' dropped with one overrun pulse.
    obs_over = 0;
    for (int s = 0; s < 3; s++) run_scan(16'(1 << 5), 0);
    for (int s = 0; s < 3; s++) run_scan('0, 0);
    for (int s = 0; s < 3; s++) run_scan(16'(1 << 3), 0);
    for (int s = 0; s < 3; s++) run_scan('0, 0);
    check_eq("overrun pulses", obs_over, 1);
    check_eq("pending code", key_if.key_code, 4'h5);
    run_scan('0, 1);

    // Long hold of 'D': one emit, or three with auto-repeat.
    obs_valid = 0;
    for (int s = 0; s < 8; s++) run_scan(16'(1 << 15), 1);
    for (int s = 0; s < 3; s++) run_scan('0, 1);
`ifdef KEYPAD_REPEAT_EN
    check_eq("hold D emits", obs_valid, 3);
`else
    check_eq("hold D emits", obs_valid, 1);
`endif

    // Random key patterns and consumer back-pressure.
    prev = '0;
    for (int s = 0; s < 120; s++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel <= 4) rp = prev;
      else if (sel <= 6) rp = '0;
      else if (sel <= 8) rp = 16'(1 << $urandom_range(0, 15));
      else rp = 16'(1 << $urandom_range(0, 7)) | 16'(1 << $urandom_range(8, 15));
      prev = rp;
      run_scan(rp, int'($urandom_range(0, 2)));
    end

    // Reset mid-scan with a key pending and held; the key is reported again afterwards.
    for (int s = 0; s < 3; s++) run_scan(16'(1 << 7), 0);
    for (int c = 0; c < 5; c++) tick(1'b0);
    do_reset();
    obs_valid = 0;
    for (int s = 0; s < 4; s++) run_scan(16'(1 << 7), 1);
    for (int s = 0; s < 3; s++) run_scan('0, 1);
    check_eq("post-reset B emits", obs_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
